// File: rtl/bridge_timer_pkg.sv
// Shared definitions for the bridge interval timer: FSM states, register map,
// CTRL field positions and MODE codes.
package bridge_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SEL_CTRL   = 2'd0,
    SEL_PRESET = 2'd1,
    SEL_COUNT  = 2'd2,
    SEL_NONE   = 2'd3
  } reg_sel_e;

  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_PRESET = 4'h4;
  localparam logic [3:0] OFF_COUNT  = 4'h8;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_MODE_LO = 1;
  localparam int unsigned CTRL_MODE_HI = 2;
  localparam int unsigned CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Reserved MODE codes fall back to one-shot behaviour.
  function automatic logic is_reload(input logic [1:0] mode);
    return mode == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/bridge_timer_decode.sv
// Combinational bridge-device decoder: window hit, access legality and
// register select for a three-register word-addressed device.
module bridge_timer_decode
  import bridge_timer_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_7F00,
  parameter logic [2:0]  MODE_WORD = 3'd0
) (
  input  logic [31:0] addr,
  input  logic        write_enable,
  input  logic [2:0]  mode,
  output logic        valid,
  output reg_sel_e    sel
);

  logic       hit;
  logic [3:0] offset;

  assign offset = {addr[3:2], 2'b00};

  always_comb begin
    sel = SEL_NONE;
    hit = 1'b0;
    if (addr[31:4] == ADDR_BASE[31:4]) begin
      unique case (offset)
        OFF_CTRL:   begin sel = SEL_CTRL;   hit = 1'b1; end
        OFF_PRESET: begin sel = SEL_PRESET; hit = 1'b1; end
        OFF_COUNT:  begin sel = SEL_COUNT;  hit = 1'b1; end
        default:    begin sel = SEL_NONE;   hit = 1'b0; end
      endcase
    end
  end

  // COUNT is read-only, so a write to it is illegal rather than ignored.
  assign valid = hit && (addr[1:0] == 2'b00) && (mode == MODE_WORD)
              && !(write_enable && (sel == SEL_COUNT));

endmodule

// File: rtl/bridge_timer.sv
// Memory-mapped countdown timer on the CPU bridge port: CTRL/PRESET/COUNT
// registers, one-shot or auto-reload countdown, and a maskable interrupt.
module bridge_timer
  import bridge_timer_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_7F00,
  parameter logic [2:0]  MODE_WORD = 3'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dev_addr,
  input  logic        dev_write_enable,
  input  logic [2:0]  dev_mode,
  input  logic [31:0] dev_write_data,
  input  logic        dev_stop,
  output logic [31:0] dev_read_result,
  output logic        dev_valid,
  output logic        irq
);

  reg_sel_e    sel;
  logic        wr_commit, ctrl_wr, preset_wr;
  logic        ctrl_en, ctrl_im;
  logic [1:0]  ctrl_mode;
  logic [31:0] preset_q, count_q, count_d;
  logic        pending_q, pending_d, pending_set;
  logic        en_d, im_d, fsm_en_clr;
  state_e      state_q, state_d;

  bridge_timer_decode #(
    .ADDR_BASE (ADDR_BASE),
    .MODE_WORD (MODE_WORD)
  ) u_decode (
    .addr         (dev_addr),
    .write_enable (dev_write_enable),
    .mode         (dev_mode),
    .valid        (dev_valid),
    .sel          (sel)
  );

  assign wr_commit = dev_valid && dev_write_enable && !dev_stop;
  assign ctrl_wr   = wr_commit && (sel == SEL_CTRL);
  assign preset_wr = wr_commit && (sel == SEL_PRESET);

  always_comb begin
    dev_read_result = '0;
    if (dev_valid) begin
      unique case (sel)
        SEL_CTRL:   dev_read_result = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
        SEL_PRESET: dev_read_result = preset_q;
        SEL_COUNT:  dev_read_result = count_q;
        default:    dev_read_result = '0;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    fsm_en_clr  = 1'b0;
    pending_set = 1'b0;
    unique case (state_q)
      IDLE: if (ctrl_en) state_d = LOAD;
      LOAD: begin
        if (!ctrl_en) begin
          state_d = IDLE;
        end else begin
          count_d = preset_q;
          state_d = CNT;
        end
      end
      CNT: begin
        if (!ctrl_en) begin
          state_d = IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = '0;
          state_d = INT;
        end
      end
      INT: begin
        pending_set = 1'b1;
        if (is_reload(ctrl_mode)) begin
          state_d = LOAD;
        end else begin
          fsm_en_clr = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Setting wins over any same-cycle clear; a CTRL write wins over the FSM's EN clear.
  always_comb begin
    pending_d = pending_q;
    if (pending_set)
      pending_d = 1'b1;
    else if (is_reload(ctrl_mode))
      pending_d = 1'b0;
    else if (ctrl_wr || preset_wr)
      pending_d = 1'b0;

    en_d = ctrl_en;
    if (ctrl_wr)
      en_d = dev_write_data[CTRL_EN];
    else if (fsm_en_clr)
      en_d = 1'b0;

    im_d = ctrl_wr ? dev_write_data[CTRL_IM] : ctrl_im;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ctrl_en   <= 1'b0;
      ctrl_mode <= MODE_ONESHOT;
      ctrl_im   <= 1'b0;
      preset_q  <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
      irq       <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      ctrl_en   <= en_d;
      ctrl_im   <= im_d;
      irq       <= pending_d && im_d;
      if (ctrl_wr)
        ctrl_mode <= dev_write_data[CTRL_MODE_HI:CTRL_MODE_LO];
      if (preset_wr)
        preset_q <= dev_write_data;
    end
  end

endmodule
